// File: rtl/alu_serial_slice_pkg.sv
// Shared op encodings, FSM state type and small helpers for the bit-serial ALU.
package alu_serial_slice_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_XOR  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_PASS = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Only ADD and SUB drive the carry chain and overflow flag.
    function automatic logic op_is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_serial_slice_if.sv
// Operand/result handshake bundle between the datapath controller and the serial ALU.
interface alu_serial_slice_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] r;
    logic             co;
    logic             v;
    logic             z;

    modport master (
        output in_valid, a, b, op, ci, out_ready,
        input  in_ready, out_valid, r, co, v, z
    );

    modport slave (
        input  in_valid, a, b, op, ci, out_ready,
        output in_ready, out_valid, r, co, v, z
    );
endinterface

// File: rtl/alu_serial_slice_slice.sv
// Combinational SLICE-bit ALU slice: ripple sum/carry chain plus result mux.
// Latency: none. Backpressure: none (pure combinational).
// b arrives pre-inverted for SUB, so SUB and ADD share the adder path.
module alu_serial_slice_slice
    import alu_serial_slice_pkg::*;
#(
    parameter int SLICE = 2
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic [2:0]       op,
    input  logic             ci,
    output logic [SLICE-1:0] r,
    output logic             co
);
    logic [SLICE:0]   c;
    logic [SLICE-1:0] sum;

    always_comb begin
        c   = '0;
        sum = '0;
        c[0] = ci;
        for (int i = 0; i < SLICE; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    // Reserved codes fall through to PASS A.
    always_comb begin
        r = a;
        case (op)
            OP_ADD, OP_SUB: r = sum;
            OP_XOR:         r = a ^ b;
            OP_AND:         r = a & b;
            OP_OR:          r = a | b;
            default:        r = a;
        endcase
    end

    assign co = op_is_arith(op) ? c[SLICE] : 1'b0;

endmodule

// File: rtl/alu_serial_slice.sv
// Bit-serial ALU: WIDTH-bit ADD/SUB/XOR/AND/OR/PASS, SLICE bits per cycle, LSB slice first.
// Latency: result/flags valid NSLICE cycles after the accept edge.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module alu_serial_slice
    import alu_serial_slice_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_serial_slice_if.slave bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt;
    logic [WIDTH-1:0]       a_sh, b_sh, res_sh, b_eff, res_nxt, r_q;
    logic [WIDTH+SLICE-1:0] res_cat;
    logic [2:0]             op_q;
    logic                   carry_q, a_msb_q, b_msb_q;
    logic                   co_q, v_q, z_q;
    logic [SLICE-1:0]       slice_r;
    logic                   slice_co;
    logic                   accept, last;

    assign accept  = bus.in_valid && (state == ST_IDLE);
    assign last    = (cnt == LAST);
    assign b_eff   = (bus.op == OP_SUB) ? ~bus.b : bus.b;
    // New slice enters at the top; after NSLICE shifts the word is LSB-aligned.
    assign res_cat = {slice_r, res_sh};
    assign res_nxt = res_cat[WIDTH+SLICE-1:SLICE];

    alu_serial_slice_slice #(.SLICE(SLICE)) u_slice (
        .a  (a_sh[SLICE-1:0]),
        .b  (b_sh[SLICE-1:0]),
        .op (op_q),
        .ci (carry_q),
        .r  (slice_r),
        .co (slice_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.in_valid)  state_nxt = ST_RUN;
            ST_RUN:  if (last)          state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            op_q    <= OP_ADD;
            carry_q <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            r_q     <= '0;
            co_q    <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
        end else if (accept) begin
            a_sh    <= bus.a;
            b_sh    <= b_eff;
            op_q    <= bus.op;
            carry_q <= (bus.op == OP_ADD) ? bus.ci : (bus.op == OP_SUB);
            cnt     <= '0;
            a_msb_q <= bus.a[WIDTH-1];
            b_msb_q <= b_eff[WIDTH-1];
        end else if (state == ST_RUN) begin
            a_sh    <= a_sh >> SLICE;
            b_sh    <= b_sh >> SLICE;
            res_sh  <= res_nxt;
            carry_q <= slice_co;
            cnt     <= cnt + 1'b1;
            if (last) begin
                r_q  <= res_nxt;
                co_q <= slice_co;
                v_q  <= op_is_arith(op_q) && (a_msb_q == b_msb_q) && (res_nxt[WIDTH-1] != a_msb_q);
                z_q  <= (res_nxt == '0);
            end
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.r         = r_q;
    assign bus.co        = co_q;
    assign bus.v         = v_q;
    assign bus.z         = z_q;

endmodule
